// File: rtl/quant_ctrl_4x4_if.sv
// Requester, quantizer and result signals of quant_ctrl_4x4; slave is the controller side, master the surrounding pipeline.
interface quant_ctrl_4x4_if #(
  parameter int BIT_LENGTH = 15,
  parameter int QP_WIDTH   = 6
) ();
  logic                         intra_valid;
  logic                         intra_ready;
  logic [QP_WIDTH-1:0]          intra_qp;
  logic [15:0][BIT_LENGTH:0]    intra_coeffs;
  logic                         inter_valid;
  logic                         inter_ready;
  logic [QP_WIDTH-1:0]          inter_qp;
  logic [15:0][BIT_LENGTH:0]    inter_coeffs;
  logic                         q_enable;
  logic                         q_mode;
  logic [3:0]                   q_qp_div6;
  logic [2:0]                   q_qp_mod6;
  logic [4:0]                   q_qbits;
  logic [15:0][BIT_LENGTH:0]    q_coeffs;
  logic [15:0][BIT_LENGTH:0]    q_result;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_src;
  logic [15:0][BIT_LENGTH:0]    out_coeffs;

  modport slave (
    input  intra_valid, intra_qp, intra_coeffs,
    input  inter_valid, inter_qp, inter_coeffs,
    input  q_result, out_ready,
    output intra_ready, inter_ready,
    output q_enable, q_mode, q_qp_div6, q_qp_mod6, q_qbits, q_coeffs,
    output out_valid, out_src, out_coeffs
  );

  modport master (
    output intra_valid, intra_qp, intra_coeffs,
    output inter_valid, inter_qp, inter_coeffs,
    output q_result, out_ready,
    input  intra_ready, inter_ready,
    input  q_enable, q_mode, q_qp_div6, q_qp_mod6, q_qbits, q_coeffs,
    input  out_valid, out_src, out_coeffs
  );
endinterface

// File: rtl/quant_ctrl_4x4.sv
// Round-robin intra/inter front end for one shared 4x4 quantizer: accept to out_valid is QUANT_LATENCY+2 cycles, one block in flight, requesters stall until the result drains.
// Defining QUANT_CTRL_STATS_EN adds per-source completion counters and an output stall counter.
module quant_ctrl_4x4 #(
  parameter int BIT_LENGTH    = 15,
  parameter int QUANT_LATENCY = 1,
  parameter int QP_WIDTH      = 6
) (
  input  logic clk,
  input  logic reset,
  quant_ctrl_4x4_if.slave bus
`ifdef QUANT_CTRL_STATS_EN
  ,
  output logic [15:0] stat_intra_cnt,
  output logic [15:0] stat_inter_cnt,
  output logic [15:0] stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t              state;
  logic                last_intra;
  logic [3:0]          cnt;
  logic                grant_intra;
  logic                grant_inter;
  logic                xfer;
  logic [QP_WIDTH-1:0] sel_qp;
  logic [5:0]          qp_c;
  logic [3:0]          div6;
  logic [2:0]          mod6;

  // Tie goes to whichever source did not win the previous transfer.
  always_comb begin
    grant_intra = bus.intra_valid & (~bus.inter_valid | ~last_intra);
    grant_inter = bus.inter_valid & (~bus.intra_valid | last_intra);
    xfer        = (state == IDLE) & ~reset & (grant_intra | grant_inter);
    sel_qp      = grant_intra ? bus.intra_qp : bus.inter_qp;
    qp_c        = (sel_qp > QP_WIDTH'(51)) ? 6'd51 : 6'(sel_qp);
    div6        = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (qp_c >= 6'(6 * k)) div6 = 4'(k);
    end
    mod6        = 3'(qp_c - 6'(div6) * 6'd6);
  end

  assign bus.intra_ready = (state == IDLE) & ~reset & grant_intra;
  assign bus.inter_ready = (state == IDLE) & ~reset & grant_inter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_intra     <= 1'b0;
      cnt            <= 4'd0;
      bus.q_enable   <= 1'b0;
      bus.q_mode     <= 1'b0;
      bus.q_qp_div6  <= 4'd0;
      bus.q_qp_mod6  <= 3'd0;
      bus.q_qbits    <= 5'd0;
      bus.q_coeffs   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_src    <= 1'b0;
      bus.out_coeffs <= '0;
`ifdef QUANT_CTRL_STATS_EN
      stat_intra_cnt <= 16'd0;
      stat_inter_cnt <= 16'd0;
      stat_stall_cnt <= 16'd0;
`endif
    end else begin
      bus.q_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            state         <= ISSUE;
            bus.q_enable  <= 1'b1;
            bus.q_mode    <= grant_intra;
            bus.q_coeffs  <= grant_intra ? bus.intra_coeffs : bus.inter_coeffs;
            bus.q_qp_div6 <= div6;
            bus.q_qp_mod6 <= mod6;
            bus.q_qbits   <= 5'd15 + 5'(div6);
            last_intra    <= grant_intra;
          end
        end
        ISSUE: begin
          cnt   <= 4'(QUANT_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // The cycle the count would hit zero is the one where q_result is valid.
          if (cnt == 4'd1) begin
            bus.out_coeffs <= bus.q_result;
            bus.out_src    <= bus.q_mode;
            bus.out_valid  <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
`ifdef QUANT_CTRL_STATS_EN
            if (bus.out_src) stat_intra_cnt <= stat_intra_cnt + 16'd1;
            else             stat_inter_cnt <= stat_inter_cnt + 16'd1;
          end else begin
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quant_ctrl_4x4.sv
// Randomized bench for quant_ctrl_4x4 with a timeline reference model; runs a latency-1 and a latency-4 instance.
module tb_quant_ctrl_4x4;

  typedef logic [15:0][15:0] blk_t;

  typedef struct packed {
    logic       iready;
    logic       eready;
    logic       qen;
    logic       qmode;
    logic [3:0] div;
    logic [2:0] md;
    logic [4:0] qbits;
    blk_t       qc;
    logic       ov;
    logic       osrc;
    blk_t       oc;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       iv, ev, ordy;
  logic [5:0] iqp, eqp;
  blk_t       ic, ec, qres;
  logic       sel4;
  obs_t       o1, o4, obs;

  int n_checks = 0;
  int n_errors = 0;

  int   age, lat, exp_qp;
  bit   mlast, exp_src;
  blk_t exp_blk;
  int   m_intra, m_inter, m_stall;
  bit   grants[$];

  quant_ctrl_4x4_if #(.BIT_LENGTH(15), .QP_WIDTH(6)) bus1 ();
  quant_ctrl_4x4_if #(.BIT_LENGTH(15), .QP_WIDTH(6)) bus4 ();

`ifdef QUANT_CTRL_STATS_EN
  logic [15:0] s1i, s1e, s1s, s4i, s4e, s4s, st_i, st_e, st_s;
  quant_ctrl_4x4 #(.BIT_LENGTH(15), .QUANT_LATENCY(1), .QP_WIDTH(6)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1),
    .stat_intra_cnt(s1i), .stat_inter_cnt(s1e), .stat_stall_cnt(s1s));
  quant_ctrl_4x4 #(.BIT_LENGTH(15), .QUANT_LATENCY(4), .QP_WIDTH(6)) dut4 (
    .clk(clk), .reset(rst), .bus(bus4),
    .stat_intra_cnt(s4i), .stat_inter_cnt(s4e), .stat_stall_cnt(s4s));
  assign st_i = sel4 ? s4i : s1i;
  assign st_e = sel4 ? s4e : s1e;
  assign st_s = sel4 ? s4s : s1s;
`else
  quant_ctrl_4x4 #(.BIT_LENGTH(15), .QUANT_LATENCY(1), .QP_WIDTH(6)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1));
  quant_ctrl_4x4 #(.BIT_LENGTH(15), .QUANT_LATENCY(4), .QP_WIDTH(6)) dut4 (
    .clk(clk), .reset(rst), .bus(bus4));
`endif

  assign bus1.intra_valid = iv;   assign bus4.intra_valid = iv;
  assign bus1.inter_valid = ev;   assign bus4.inter_valid = ev;
  assign bus1.intra_qp = iqp;     assign bus4.intra_qp = iqp;
  assign bus1.inter_qp = eqp;     assign bus4.inter_qp = eqp;
  assign bus1.intra_coeffs = ic;  assign bus4.intra_coeffs = ic;
  assign bus1.inter_coeffs = ec;  assign bus4.inter_coeffs = ec;
  assign bus1.q_result = qres;    assign bus4.q_result = qres;
  assign bus1.out_ready = ordy;   assign bus4.out_ready = ordy;

  assign o1 = {bus1.intra_ready, bus1.inter_ready, bus1.q_enable, bus1.q_mode, bus1.q_qp_div6,
               bus1.q_qp_mod6, bus1.q_qbits, bus1.q_coeffs, bus1.out_valid, bus1.out_src, bus1.out_coeffs};
  assign o4 = {bus4.intra_ready, bus4.inter_ready, bus4.q_enable, bus4.q_mode, bus4.q_qp_div6,
               bus4.q_qp_mod6, bus4.q_qbits, bus4.q_coeffs, bus4.out_valid, bus4.out_src, bus4.out_coeffs};
  assign obs = sel4 ? o4 : o1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = 16'($urandom);
    return b;
  endfunction

  // Stand-in quantizer transform; only its value at the right cycle matters.
  function automatic blk_t quant(input blk_t b);
    return b ^ {16{16'hA5C3}};
  endfunction

  task automatic chk_reset_vals();
    chk("rst_intra_ready", obs.iready, 0);
    chk("rst_inter_ready", obs.eready, 0);
    chk("rst_q_enable", obs.qen, 0);
    chk("rst_q_mode", obs.qmode, 0);
    chk("rst_div6", obs.div, 0);
    chk("rst_mod6", obs.md, 0);
    chk("rst_qbits", obs.qbits, 0);
    chk("rst_q_coeffs", obs.qc, 0);
    chk("rst_out_valid", obs.ov, 0);
    chk("rst_out_src", obs.osrc, 0);
    chk("rst_out_coeffs", obs.oc, 0);
`ifdef QUANT_CTRL_STATS_EN
    chk("rst_stat_intra", st_i, 0);
    chk("rst_stat_inter", st_e, 0);
    chk("rst_stat_stall", st_s, 0);
`endif
  endtask

  task automatic reset_dut(input int n);
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; ev = 1'b0; ordy = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    age = 0; mlast = 1'b0; m_intra = 0; m_inter = 0; m_stall = 0;
    #1;
    chk_reset_vals();
  endtask

  // One clock cycle: drive inputs, compare against the timeline model, advance the model.
  task automatic step(input bit vi, input bit ve, input int qi, input int qe, input bit ordy_in);
    bit gi, ge;
    int qc;
    @(negedge clk);
    iv = vi; ev = ve; iqp = 6'(qi); eqp = 6'(qe);
    ic = rand_blk(); ec = rand_blk(); ordy = ordy_in;
    qres = (age == 1 + lat) ? quant(exp_blk) : rand_blk();
    #1;
`ifdef QUANT_CTRL_STATS_EN
    chk("stat_intra", st_i, 16'(m_intra));
    chk("stat_inter", st_e, 16'(m_inter));
    chk("stat_stall", st_s, 16'(m_stall));
`endif
    if (age == 0) begin
      gi = vi && (!ve || !mlast);
      ge = ve && (!vi || mlast);
      chk("intra_ready", obs.iready, gi);
      chk("inter_ready", obs.eready, ge);
      chk("idle_q_enable", obs.qen, 0);
      chk("idle_out_valid", obs.ov, 0);
      if ((obs.iready && vi) || (obs.eready && ve)) grants.push_back(obs.iready);
      if (gi || ge) begin
        exp_src = gi;
        exp_blk = gi ? ic : ec;
        exp_qp  = gi ? qi : qe;
        mlast   = gi;
        age     = 1;
      end
    end else begin
      qc = (exp_qp > 51) ? 51 : exp_qp;
      chk("busy_intra_ready", obs.iready, 0);
      chk("busy_inter_ready", obs.eready, 0);
      chk("q_enable", obs.qen, age == 1);
      chk("out_valid", obs.ov, age >= 2 + lat);
      chk("q_mode", obs.qmode, exp_src);
      chk("q_coeffs", obs.qc, exp_blk);
      chk("q_qp_div6", obs.div, qc / 6);
      chk("q_qp_mod6", obs.md, qc % 6);
      chk("q_qbits", obs.qbits, 15 + qc / 6);
      if (age >= 2 + lat) begin
        chk("out_src", obs.osrc, exp_src);
        chk("out_coeffs", obs.oc, quant(exp_blk));
        if (ordy_in) begin
          if (exp_src) m_intra++; else m_inter++;
          age = 0;
        end else begin
          m_stall++;
        end
      end else begin
        age++;
      end
    end
  endtask

  initial begin
    int stall0;
    rst = 1'b1; iv = 1'b0; ev = 1'b0; ordy = 1'b0;
    iqp = '0; eqp = '0; ic = '0; ec = '0; qres = '0;
    sel4 = 1'b0; lat = 1; age = 0; mlast = 1'b0; exp_src = 1'b0; exp_blk = '0; exp_qp = 0;
    m_intra = 0; m_inter = 0; m_stall = 0;
    reset_dut(2);

    // Single intra request, QP 27.
    step(1, 0, 27, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_q_enable", obs.qen, 1);
    chk("t1_q_mode", obs.qmode, 1);
    chk("t1_div6", obs.div, 4);
    chk("t1_mod6", obs.md, 3);
    chk("t1_qbits", obs.qbits, 19);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_out_valid", obs.ov, 1);
    chk("t1_out_src", obs.osrc, 1);
    repeat (2) step(0, 0, 0, 0, 1);

    // Both requesters continuously valid: strict alternation starting with intra.
    reset_dut(1);
    grants.delete();
    repeat (24) step(1, 1, $urandom_range(0, 63), $urandom_range(0, 63), 1);
    chk("rr_grant_count", grants.size(), 6);
    for (int i = 0; i < grants.size() && i < 6; i++) chk("rr_grant_order", grants[i], (i % 2) == 0);

    // QP clamp on the inter path.
    step(0, 1, 0, 63, 1);
    step(0, 0, 0, 0, 1);
    chk("clamp_div6", obs.div, 8);
    chk("clamp_mod6", obs.md, 3);
    chk("clamp_qbits", obs.qbits, 23);
    repeat (3) step(0, 0, 0, 0, 1);

    // Ten cycles of output backpressure with intra still requesting.
    step(1, 0, 20, 0, 0);
    step(1, 0, 20, 0, 0);
    step(1, 0, 20, 0, 0);
    stall0 = m_stall;
    repeat (10) step(1, 0, 20, 0, 0);
    chk("bp_stall_cycles", m_stall - stall0, 10);
`ifdef QUANT_CTRL_STATS_EN
    chk("bp_stat_stall", st_s, 16'(stall0 + 10));
`endif
    step(0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    // Random traffic on the latency-1 instance.
    repeat (400) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63),
                      $urandom_range(0, 63), $urandom_range(0, 3) != 0);

    // Latency-4 instance: reset during the second WAIT cycle.
    sel4 = 1'b1; lat = 4;
    reset_dut(1);
    step(1, 0, 30, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    reset_dut(1);
    repeat (8) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 40, 1);
    chk("post_rst_accepted", age, 1);
    repeat (7) step(0, 0, 0, 0, 1);

    repeat (300) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63),
                      $urandom_range(0, 63), $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
